sipo_stream: RTL and testbench
==============================

// Module: sipo_stream
// PURPOSE
//  Parametrised serial-in/parallel-out packer with valid/ready flow control on both sides.
//  Gathers WIDTH-bit beats into a word of up to MAX_NUM lanes. The beat count per word is
//  run-time programmable, and s_last can close a word early with a partial flush.
//  Beat order in the word is selectable. Sits between narrow streaming sources and wide
//  datapath consumers.
// PARAMETERS
//  WIDTH      8   bits per serial beat
//  MAX_NUM    4   max beats (lanes) per output word, >=1
//  MSB_FIRST  0   0: beat k -> lane k (bits [k*WIDTH +: WIDTH]); 1: beat k -> lane MAX_NUM-1-k
//  NW = $clog2(MAX_NUM+1) (localparam, counter/config width)
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  rstn       in   1               synchronous reset, active-low
//  cfg_num    in   NW              beats per word; 0 or >MAX_NUM treated as MAX_NUM
//  s_data     in   WIDTH           serial beat
//  s_valid    in   1               beat valid
//  s_last     in   1               beat is last of frame; closes current word
//  s_ready    out  1               beat accepted when s_valid && s_ready
//  m_data     out  WIDTH*MAX_NUM   packed word
//  m_valid    out  1               word valid; held until m_ready
//  m_ready    in   1               consumer accepts word when m_valid && m_ready
//  m_count    out  NW              beats held in m_data (1..MAX_NUM)
//  m_last     out  1               word was closed by s_last
// BEHAVIOUR
//  Reset (rstn=0 at edge)
//   - acc_data=0, acc_cnt=0, m_data=0, m_valid=0, m_count=0, m_last=0.
//   - Reset mid-word discards the partial word and any pending output word.
//   - s_ready reads 0 while rstn=0.
//  Flow control
//   - s_ready = rstn && !(m_valid && !m_ready) (combinational; stalls input only while output is blocked).
//   - m_data, m_count and m_last stay stable while m_valid && !m_ready.
//   - m_valid must not drop until the word is taken.
//  Config latch
//   - cfg_num is sampled on the first accepted beat of a word (acc_cnt==0) into num_q.
//   - Changes mid-word are ignored until the next word.
//  Accept beat (s_valid && s_ready)
//   - Beat is written into its lane: k=acc_cnt, or MAX_NUM-1-acc_cnt if MSB_FIRST.
//   - The beat is complete when acc_cnt+1 == num (num = num_q, or the cfg value if acc_cnt==0) OR s_last=1.
//   - Complete beat: at the same edge, m_data = accumulated lanes including this beat.
//       - m_data lanes never written in this word are zero.
//       - m_count=acc_cnt+1, m_last=s_last, m_valid=1.
//       - acc_data and acc_cnt clear to 0.
//   - Otherwise: acc_cnt increments.
//  Latency and throughput
//   - m_valid rises 1 cycle after the completing beat is accepted.
//   - With m_ready=1 held, one beat per cycle is sustained with no bubbles.
//  Output handshake
//   - m_valid && m_ready with no new complete beat: m_valid clears next edge.
//   - m_data keeps its value after the handshake.
//   - Take and a new complete beat in the same cycle: the new word loads, m_valid stays 1.
//  Boundaries
//   - s_last on beat 0: 1-beat word, m_count=1, m_last=1.
//   - cfg_num=1: every beat is emitted as its own word.
//   - acc_cnt never exceeds MAX_NUM-1; there is no overflow path.
//   - s_valid=0 mid-word holds the partial word. There is no timeout flush.
// TESTING
//  - Reset: drive rstn=0 mid-word, then release.
//      -> m_valid=0, m_data=0, and the next word starts at lane 0.
//  - LSB order: WIDTH=8, MAX_NUM=4, cfg_num=4, m_ready=1, beats 11,22,33,44 on back-to-back cycles.
//      -> m_data=0x44332211, m_count=4, m_last=0, 1 cycle after beat 44.
//  - MSB order: MSB_FIRST=1, same beats as the LSB test.
//      -> m_data=0x11223344.
//  - Early close: cfg_num=4, beats AA,BB with s_last on BB.
//      -> m_data=0x0000BBAA, m_count=2, m_last=1.
//  - Backpressure: m_ready=0 after the first word completes.
//      -> s_ready=0, m_data stable; accepts resume after m_ready=1, no beat lost or duplicated.
//  - Streaming: cfg_num=2, 8 beats 01..08, m_ready=1 throughout.
//      -> words 0x0201,0x0403,0x0605,0x0807 on consecutive odd cycles.
//      -> cfg_num changed to 3 mid-word takes effect only on the following word.

Source files
------------

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out packer: gathers WIDTH-bit beats into a word of up to MAX_NUM lanes,
// with a run-time beat count, early close on s_last and valid/ready flow control on both sides.
module sipo_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_NUM   = 4,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned NW       = $clog2(MAX_NUM + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NW-1:0]            cfg_num,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [WIDTH*MAX_NUM-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NW-1:0]            m_count,
  output logic                     m_last
);

  localparam int unsigned DW = WIDTH * MAX_NUM;
  localparam logic [NW-1:0] MaxCnt = NW'(MAX_NUM);

  logic [DW-1:0] acc_data_q;
  logic [NW-1:0] acc_cnt_q;
  logic [NW-1:0] num_q;
  logic [DW-1:0] m_data_q;
  logic          m_valid_q;
  logic [NW-1:0] m_count_q;
  logic          m_last_q;

  logic [DW-1:0] merged;
  logic [NW-1:0] cfg_eff;
  logic [NW-1:0] num;
  logic [NW-1:0] cnt_inc;
  logic [NW-1:0] lane;
  logic          accept;
  logic          complete;

  // Input only stalls while a finished word is waiting on the consumer.
  assign s_ready = rstn && !(m_valid_q && !m_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    cfg_eff  = ((cfg_num == '0) || (cfg_num > MaxCnt)) ? MaxCnt : cfg_num;
    num      = (acc_cnt_q == '0) ? cfg_eff : num_q;
    cnt_inc  = acc_cnt_q + NW'(1);
    lane     = MSB_FIRST ? (MaxCnt - NW'(1) - acc_cnt_q) : acc_cnt_q;
    complete = accept && ((cnt_inc == num) || s_last);
    merged   = acc_data_q;
    for (int unsigned i = 0; i < MAX_NUM; i++) begin
      if (lane == NW'(i)) begin
        merged[i*WIDTH +: WIDTH] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_data_q <= '0;
      acc_cnt_q  <= '0;
      num_q      <= MaxCnt;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_count_q  <= '0;
      m_last_q   <= 1'b0;
    end else begin
      if (accept && (acc_cnt_q == '0)) begin
        num_q <= cfg_eff;
      end
      if (complete) begin
        m_data_q   <= merged;
        m_count_q  <= cnt_inc;
        m_last_q   <= s_last;
        m_valid_q  <= 1'b1;
        acc_data_q <= '0;
        acc_cnt_q  <= '0;
      end else begin
        if (accept) begin
          acc_data_q <= merged;
          acc_cnt_q  <= cnt_inc;
        end
        // m_data is left untouched after the take; only valid drops.
        if (m_valid_q && m_ready) begin
          m_valid_q <= 1'b0;
        end
      end
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_count = m_count_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_sipo_stream.sv
// Bench for sipo_stream: LSB- and MSB-ordered instances share stimulus; a queue-based
// reference model feeds a scoreboard monitor that checks every presented output word.
module tb_sipo_stream;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NW = 3;
  localparam int DW = W * N;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NW-1:0] cfg_num;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          m_ready;

  logic          s_ready0, s_ready1;
  logic [DW-1:0] m_data0, m_data1;
  logic          m_valid0, m_valid1;
  logic [NW-1:0] m_count0, m_count1;
  logic          m_last0, m_last1;

  always #5 clk = ~clk;

  sipo_stream #(.WIDTH(W), .MAX_NUM(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .cfg_num(cfg_num), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready), .m_count(m_count0), .m_last(m_last0)
  );

  sipo_stream #(.WIDTH(W), .MAX_NUM(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .cfg_num(cfg_num), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_count(m_count1), .m_last(m_last1)
  );

  typedef struct {
    logic [DW-1:0] lsb;
    logic [DW-1:0] msb;
    logic [NW-1:0] cnt;
    logic          last;
  } word_t;

  word_t        exp_q[$];
  logic [W-1:0] beats[$];
  int           num_cur = N;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect accepted beats in a list; emit a word when the count is reached or on last.
  task automatic model_accept(input logic [W-1:0] d, input logic last, input logic [NW-1:0] cfg);
    word_t w;
    if (beats.size() == 0) num_cur = (cfg == 0 || int'(cfg) > N) ? N : int'(cfg);
    beats.push_back(d);
    if (beats.size() == num_cur || last) begin
      w.lsb = '0;
      w.msb = '0;
      foreach (beats[k]) begin
        w.lsb[k*W +: W]       = beats[k];
        w.msb[(N-1-k)*W +: W] = beats[k];
      end
      w.cnt  = NW'(beats.size());
      w.last = last;
      exp_q.push_back(w);
      beats.delete();
    end
  endtask

  // One clock: inputs were set at posedge+1; decide acceptance mid-cycle, update model at the edge.
  task automatic step(output bit acc);
    logic exp_rdy;
    @(negedge clk);
    #1;
    exp_rdy = rstn && (m_ready || exp_q.size() == 0);
    check("s_ready", 64'(s_ready0), 64'(exp_rdy));
    check("s_ready_msb", 64'(s_ready1), 64'(exp_rdy));
    acc = s_valid && s_ready0;
    @(posedge clk);
    if (acc) model_accept(s_data, s_last, cfg_num);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    bit acc;
    int tries = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      step(acc);
      tries++;
    end while (!acc && tries < 50);
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(acc);
  endtask

  // Scoreboard monitor: output valid must track the model queue; the front word is compared
  // every cycle it is presented and popped on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("m_valid", 64'(m_valid0), 64'(exp_q.size() != 0));
        check("m_valid_msb", 64'(m_valid1), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0 && m_valid0) begin
          check("m_data", 64'(m_data0), 64'(exp_q[0].lsb));
          check("m_data_msb", 64'(m_data1), 64'(exp_q[0].msb));
          check("m_count", 64'(m_count0), 64'(exp_q[0].cnt));
          check("m_last", 64'(m_last0), 64'(exp_q[0].last));
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rstn    = 1'b0;
    cfg_num = 3'd4;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid0), 64'(0));
    check("rst_m_data", 64'(m_data0), 64'(0));
    check("rst_m_count", 64'(m_count0), 64'(0));
    check("rst_m_last", 64'(m_last0), 64'(0));
    check("rst_s_ready", 64'(s_ready0), 64'(0));
    rstn = 1'b1;

    // Full word, both lane orders
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("lsb_word", 64'(m_data0), 64'(32'h44332211));
    check("msb_word", 64'(m_data1), 64'(32'h11223344));
    check("lsb_count", 64'(m_count0), 64'(4));
    check("lsb_last", 64'(m_last0), 64'(0));
    check("lsb_valid", 64'(m_valid0), 64'(1));
    idle(2);

    // Early close on s_last
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("early_word", 64'(m_data0), 64'(32'h0000BBAA));
    check("early_word_msb", 64'(m_data1), 64'(32'hAABB0000));
    check("early_count", 64'(m_count0), 64'(2));
    check("early_last", 64'(m_last0), 64'(1));
    idle(2);

    // s_last on the first beat
    send(8'h5A, 1'b1);
    check("one_beat_word", 64'(m_data0), 64'(32'h0000005A));
    check("one_beat_count", 64'(m_count0), 64'(1));
    idle(1);

    // Streaming with two beats per word
    cfg_num = 3'd2;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("stream_last_word", 64'(m_data0), 64'(32'h00000807));

    // Config change mid-word applies to the next word only
    send(8'h09, 1'b0);
    cfg_num = 3'd3;
    send(8'h0A, 1'b0);
    check("cfg_hold_word", 64'(m_data0), 64'(32'h00000A09));
    check("cfg_hold_count", 64'(m_count0), 64'(2));
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b0);
    check("cfg_new_word", 64'(m_data0), 64'(32'h000D0C0B));
    check("cfg_new_count", 64'(m_count0), 64'(3));
    idle(2);

    // Every beat its own word
    cfg_num = 3'd1;
    for (int i = 0; i < 3; i++) send(8'(8'h70 + i), 1'b0);
    check("cfg1_count", 64'(m_count0), 64'(1));
    idle(1);

    // Backpressure: input stalls, output word holds
    cfg_num = 3'd2;
    m_ready = 1'b0;
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h23;
    repeat (3) begin
      step(acc);
      check("bp_stall", 64'(acc), 64'(0));
      check("bp_hold", 64'(m_data0), 64'(32'h00002221));
    end
    m_ready = 1'b1;
    send(8'h23, 1'b0);
    send(8'h24, 1'b0);
    idle(2);

    // Out-of-range configs behave as MAX_NUM
    for (int c = 0; c < 8; c += 5) begin
      cfg_num = NW'(c == 0 ? 0 : c);
      for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
      check("cfg_oor_count", 64'(m_count0), 64'(4));
    end
    cfg_num = 3'd7;
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
    check("cfg7_count", 64'(m_count0), 64'(4));
    idle(2);

    // Reset mid-word discards the partial word
    cfg_num = 3'd4;
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    rstn = 1'b0;
    step(acc);
    exp_q.delete();
    beats.delete();
    check("midrst_m_valid", 64'(m_valid0), 64'(0));
    check("midrst_m_data", 64'(m_data0), 64'(0));
    rstn = 1'b1;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    check("postrst_word", 64'(m_data0), 64'(32'h64636261));

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = 8'($urandom);
      s_last  = ($urandom % 6) == 0;
      m_ready = ($urandom % 3) != 0;
      if ($urandom % 16 == 0) cfg_num = NW'($urandom);
      step(acc);
    end

    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(acc);
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
